interrupt_controller: RTL and testbench

Prioritising interrupt front-end that sits directly upstream of the multi-cycle control unit. It latches external maskable and non-maskable requests and drives the control unit's `nmint`, `interrupt` and `busy` inputs. On the control unit's `savePC` acknowledge it captures the interrupted PC into an EPC register and presents the vector address and source ID. It holds off further requests until the control unit reports the end of the service routine.

---
 rtl/interrupt_pkg.sv | 23 ++
 rtl/interrupt_controller_if.sv | 35 +++
 rtl/irq_priority_enc.sv | 22 ++
 rtl/interrupt_controller.sv | 182 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt front-end and the control unit.
package interrupt_pkg;

  // Width of the source ID presented to the control unit.
  localparam int unsigned IdW = 3;

  // Source ID reported while an NMI is in service.
  localparam logic [IdW-1:0] NMI_ID = 3'd7;

  // Default vector addresses. The control unit uses the same constants for its
  // PCSrc=3 path and for its end-of-ISR PC comparison.
  localparam logic [31:0] MI_VECTOR_DEFAULT  = 32'd40;
  localparam logic [31:0] NMI_VECTOR_DEFAULT = 32'd60;

  // Service state of the front-end.
  typedef enum logic [1:0] {
    StIdle,
    StReqMi,
    StReqNmi,
    StSvc
  } irq_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/acknowledge bundle between the interrupt sources, the control unit
// and the interrupt front-end.
interface interrupt_controller_if #(
  parameter int unsigned NUM_IRQ = 4
) ();

  logic [NUM_IRQ-1:0] irq_in;
  logic               nmi_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               save_pc;
  logic [31:0]        pc_in;
  logic               isr_done;

  logic               nmint;
  logic               interrupt;
  logic               busy;
  logic [31:0]        vector;
  logic [2:0]         irq_id;
  logic [31:0]        epc;
  logic [NUM_IRQ-1:0] pending;

  // Sources and control unit side.
  modport master (
    output irq_in, nmi_in, mask_we, mask_wdata, save_pc, pc_in, isr_done,
    input  nmint, interrupt, busy, vector, irq_id, epc, pending
  );

  // Interrupt front-end side.
  modport slave (
    input  irq_in, nmi_in, mask_we, mask_wdata, save_pc, pc_in, isr_done,
    output nmint, interrupt, busy, vector, irq_id, epc, pending
  );

endinterface

// File: rtl/irq_priority_enc.sv
// Lowest-index-first priority encoder over the enabled pending requests.
module irq_priority_enc #(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [2:0]         id
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = 3'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising interrupt front-end for the multi-cycle control unit: edge
// detection, sticky pending bits, masking, NMI precedence and EPC capture.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] MI_VECTOR  = MI_VECTOR_DEFAULT,
  parameter logic [31:0] NMI_VECTOR = NMI_VECTOR_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  interrupt_controller_if.slave bus
);

  irq_state_e         state_q, state_d;

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] irq_arm_q, irq_arm_d;
  logic               nmi_q, nmi_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_arm_q, nmi_arm_d;
  logic               edge_vld_q, edge_vld_d;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;

  logic [2:0]         irq_id_q, irq_id_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        vector_q, vector_d;
  logic               nmint_q, nmint_d;
  logic               interrupt_q, interrupt_d;
  logic               busy_q, busy_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] enabled_req;
  logic               enc_valid;
  logic [2:0]         enc_id;
  logic [NUM_IRQ-1:0] winner_oh;
  logic               winner_en;
  logic [NUM_IRQ-1:0] irq_clr;
  logic               nmi_clr;

  assign enabled_req = pending_q & mask_q;

  irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_priority_enc (
    .req   (enabled_req),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Winner latched on entry to the maskable request state.
  assign winner_oh = NUM_IRQ'(1) << irq_id_q;
  assign winner_en = |(mask_q & winner_oh);

  // Edge detection, pending/mask bookkeeping and the service FSM.
  always_comb begin
    irq_d       = bus.irq_in;
    irq_prev_d  = irq_q;
    nmi_d       = bus.nmi_in;
    nmi_prev_d  = nmi_q;
    edge_vld_d  = 1'b1;
    // A line is only armed once it has been seen low after reset, so a line
    // held high through reset cannot raise a request until it toggles.
    irq_arm_d   = irq_arm_q | ({NUM_IRQ{edge_vld_q}} & ~irq_q);
    nmi_arm_d   = nmi_arm_q | (edge_vld_q & ~nmi_q);
    irq_rise    = irq_q & ~irq_prev_q & irq_arm_q;
    nmi_rise    = nmi_q & ~nmi_prev_q & nmi_arm_q;

    state_d     = state_q;
    irq_id_d    = irq_id_q;
    epc_d       = epc_q;
    irq_clr     = '0;
    nmi_clr     = 1'b0;
    mask_d      = bus.mask_we ? bus.mask_wdata : mask_q;

    unique case (state_q)
      StIdle: begin
        if (nmi_pend_q) begin
          state_d = StReqNmi;
        end else if (enc_valid) begin
          state_d  = StReqMi;
          irq_id_d = enc_id;
        end
      end
      StReqMi: begin
        // An acknowledge already issued by the control unit takes precedence.
        if (bus.save_pc) begin
          epc_d   = bus.pc_in;
          irq_clr = winner_oh;
          state_d = StSvc;
        end else if (nmi_pend_q) begin
          state_d = StReqNmi;
        end else if (!winner_en) begin
          state_d = StIdle;
        end
      end
      StReqNmi: begin
        if (bus.save_pc) begin
          epc_d    = bus.pc_in;
          nmi_clr  = 1'b1;
          irq_id_d = NMI_ID;
          state_d  = StSvc;
        end
      end
      StSvc: begin
        if (bus.isr_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new edge on the source being acknowledged keeps its pending bit set.
    pending_d   = (pending_q & ~irq_clr) | irq_rise;
    nmi_pend_d  = (nmi_pend_q & ~nmi_clr) | nmi_rise;

    nmint_d     = (state_d == StReqNmi);
    interrupt_d = (state_d == StReqMi);
    busy_d      = (state_d == StSvc) || (state_d == StReqNmi);
    vector_d    = vector_q;
    if (state_d == StReqNmi) begin
      vector_d = NMI_VECTOR;
    end else if (state_d == StReqMi) begin
      vector_d = MI_VECTOR;
    end
  end

  // All state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      irq_q       <= '0;
      irq_prev_q  <= '0;
      irq_arm_q   <= '0;
      nmi_q       <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_arm_q   <= 1'b0;
      edge_vld_q  <= 1'b0;
      pending_q   <= '0;
      nmi_pend_q  <= 1'b0;
      mask_q      <= '1;
      irq_id_q    <= 3'd0;
      epc_q       <= 32'd0;
      vector_q    <= MI_VECTOR;
      nmint_q     <= 1'b0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      irq_prev_q  <= irq_prev_d;
      irq_arm_q   <= irq_arm_d;
      nmi_q       <= nmi_d;
      nmi_prev_q  <= nmi_prev_d;
      nmi_arm_q   <= nmi_arm_d;
      edge_vld_q  <= edge_vld_d;
      pending_q   <= pending_d;
      nmi_pend_q  <= nmi_pend_d;
      mask_q      <= mask_d;
      irq_id_q    <= irq_id_d;
      epc_q       <= epc_d;
      vector_q    <= vector_d;
      nmint_q     <= nmint_d;
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.nmint     = nmint_q;
  assign bus.interrupt = interrupt_q;
  assign bus.busy      = busy_q;
  assign bus.vector    = vector_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.epc       = epc_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed by
// randomized request bursts checked against a priority/pending model.
module tb_interrupt_controller;
  import interrupt_pkg::*;

  localparam int unsigned N = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: sticky pending sets, NMI flag and mask.
  logic [N-1:0] m_pend = '0;
  logic         m_nmi  = 1'b0;
  logic [N-1:0] m_mask = '1;

  interrupt_controller_if #(.NUM_IRQ(N)) bus ();

  interrupt_controller #(
    .NUM_IRQ    (N),
    .MI_VECTOR  (32'd40),
    .NMI_VECTOR (32'd60)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".nmint"},     32'(bus.nmint),     32'd0);
    check({tag, ".interrupt"}, 32'(bus.interrupt), 32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".vector"},    bus.vector,         32'd40);
    check({tag, ".irq_id"},    32'(bus.irq_id),    32'd0);
    check({tag, ".epc"},       bus.epc,            32'd0);
    check({tag, ".pending"},   32'(bus.pending),   32'd0);
  endtask

  task automatic pulse(input logic [N-1:0] irqs, input logic nmi);
    bus.irq_in = irqs;
    bus.nmi_in = nmi;
    step();
    bus.irq_in = '0;
    bus.nmi_in = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    step();
    bus.mask_we    = 1'b0;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.save_pc = 1'b1;
    bus.pc_in   = pc;
    step();
    bus.save_pc = 1'b0;
  endtask

  task automatic finish_isr();
    bus.isr_done = 1'b1;
    step();
    bus.isr_done = 1'b0;
  endtask

  // Bounded wait for a request line; a timeout shows up as a failed check.
  task automatic wait_req(input logic nmi, input string tag);
    int n = 0;
    while (((nmi ? bus.nmint : bus.interrupt) !== 1'b1) && n < 16) begin
      step();
      n++;
    end
    check({tag, ".req"}, 32'(nmi ? bus.nmint : bus.interrupt), 32'd1);
  endtask

  function automatic int unsigned lowest(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Serve everything the model says is serviceable, in priority order.
  task automatic serve_model(input string tag);
    logic [31:0] pc;
    int unsigned id;
    while (m_nmi || |(m_pend & m_mask)) begin
      pc = $urandom;
      if (m_nmi) begin
        wait_req(1'b1, {tag, ".nmi"});
        check({tag, ".nmi.mi_low"}, 32'(bus.interrupt), 32'd0);
        check({tag, ".nmi.vector"}, bus.vector, 32'd60);
        ack(pc);
        m_nmi = 1'b0;
        check({tag, ".nmi.irq_id"}, 32'(bus.irq_id), 32'd7);
      end else begin
        id = lowest(m_pend & m_mask);
        wait_req(1'b0, {tag, ".mi"});
        check({tag, ".mi.vector"}, bus.vector, 32'd40);
        check({tag, ".mi.irq_id"}, 32'(bus.irq_id), id);
        ack(pc);
        m_pend[id] = 1'b0;
        check({tag, ".mi.ack_id"}, 32'(bus.irq_id), id);
      end
      check({tag, ".epc"},     bus.epc,          pc);
      check({tag, ".busy"},    32'(bus.busy),    32'd1);
      check({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
      finish_isr();
    end
    step(6);
    check({tag, ".quiet.mi"},  32'(bus.interrupt), 32'd0);
    check({tag, ".quiet.nmi"}, 32'(bus.nmint),     32'd0);
    check({tag, ".leftover"},  32'(bus.pending),   32'(m_pend));
  endtask

  initial begin
    logic [N-1:0] bits;
    logic [N-1:0] msk;
    logic         nmi;

    bus.irq_in     = '0;
    bus.nmi_in     = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.save_pc    = 1'b0;
    bus.pc_in      = '0;
    bus.isr_done   = 1'b0;

    // Reset values.
    reset = 1'b1;
    step(3);
    check_reset_vals("reset");
    reset = 1'b0;
    step(3);

    // Single IRQ: edge latency, acknowledge and completion.
    bus.irq_in = 4'b0100;
    step();
    bus.irq_in = '0;
    step();
    check("t1.pend_n2",  32'(bus.pending),   32'h4);
    check("t1.req_n2",   32'(bus.interrupt), 32'd0);
    step();
    check("t1.req_n3",   32'(bus.interrupt), 32'd1);
    check("t1.vector",   bus.vector,         32'd40);
    check("t1.nmint",    32'(bus.nmint),     32'd0);
    check("t1.busy_req", 32'(bus.busy),      32'd0);
    ack(32'h1C);
    check("t1.epc",      bus.epc,            32'h1C);
    check("t1.irq_id",   32'(bus.irq_id),    32'd2);
    check("t1.pend_clr", 32'(bus.pending),   32'd0);
    check("t1.busy_svc", 32'(bus.busy),      32'd1);
    check("t1.req_drop", 32'(bus.interrupt), 32'd0);
    ack(32'hDEAD);
    check("t1.svc_ack_ignored", bus.epc, 32'h1C);
    finish_isr();
    check("t1.busy_idle", 32'(bus.busy), 32'd0);
    ack(32'hBEEF);
    check("t1.idle_ack_ignored", bus.epc, 32'h1C);
    step(4);
    check("t1.quiet", 32'(bus.interrupt), 32'd0);

    // Priority: simultaneous sources, lowest index first.
    pulse(4'b1010, 1'b0);
    wait_req(1'b0, "t2a");
    check("t2a.irq_id",  32'(bus.irq_id),  32'd1);
    check("t2a.pending", 32'(bus.pending), 32'hA);
    ack(32'h200);
    check("t2a.pend_clr", 32'(bus.pending), 32'h8);
    finish_isr();
    wait_req(1'b0, "t2b");
    check("t2b.irq_id", 32'(bus.irq_id), 32'd3);
    ack(32'h204);
    finish_isr();

    // NMI preemption of a maskable request.
    pulse(4'b0001, 1'b0);
    wait_req(1'b0, "t3a");
    check("t3a.irq_id", 32'(bus.irq_id), 32'd0);
    pulse('0, 1'b1);
    wait_req(1'b1, "t3nmi");
    check("t3nmi.mi_low",  32'(bus.interrupt), 32'd0);
    check("t3nmi.vector",  bus.vector,         32'd60);
    check("t3nmi.busy",    32'(bus.busy),      32'd1);
    check("t3nmi.pending", 32'(bus.pending),   32'h1);
    ack(32'h300);
    check("t3nmi.irq_id", 32'(bus.irq_id), 32'd7);
    check("t3nmi.epc",    bus.epc,         32'h300);
    finish_isr();
    wait_req(1'b0, "t3b");
    check("t3b.irq_id", 32'(bus.irq_id), 32'd0);
    ack(32'h304);
    check("t3b.pending", 32'(bus.pending), 32'd0);
    finish_isr();

    // Masking suppresses but keeps pending; unmasking releases it.
    write_mask(4'b1110);
    pulse(4'b0001, 1'b0);
    step(4);
    check("t4.masked_req", 32'(bus.interrupt), 32'd0);
    check("t4.masked_pnd", 32'(bus.pending),   32'h1);
    write_mask(4'b1111);
    step();
    check("t4.unmask_req", 32'(bus.interrupt), 32'd1);
    check("t4.irq_id",     32'(bus.irq_id),    32'd0);
    ack(32'h400);
    finish_isr();

    // No requests while in service; NMI wins afterwards.
    pulse(4'b0100, 1'b0);
    wait_req(1'b0, "t5a");
    ack(32'h500);
    pulse(4'b0010, 1'b1);
    step(4);
    check("t5.svc_nmint", 32'(bus.nmint),     32'd0);
    check("t5.svc_mi",    32'(bus.interrupt), 32'd0);
    check("t5.svc_busy",  32'(bus.busy),      32'd1);
    check("t5.svc_pnd",   32'(bus.pending),   32'h2);
    finish_isr();
    wait_req(1'b1, "t5nmi");
    check("t5nmi.mi_low", 32'(bus.interrupt), 32'd0);
    ack(32'h504);
    check("t5nmi.irq_id", 32'(bus.irq_id), 32'd7);
    finish_isr();
    wait_req(1'b0, "t5b");
    check("t5b.irq_id", 32'(bus.irq_id), 32'd1);
    ack(32'h508);
    finish_isr();

    // Reset mid-service with a held-high line.
    pulse(4'b0100, 1'b0);
    wait_req(1'b0, "t6a");
    ack(32'h600);
    bus.irq_in = 4'b0100;
    step(3);
    check("t6.pre_pnd",  32'(bus.pending), 32'h4);
    check("t6.pre_busy", 32'(bus.busy),    32'd1);
    reset = 1'b1;
    step();
    check_reset_vals("t6.rst");
    reset = 1'b0;
    step(8);
    check("t6.held_req", 32'(bus.interrupt), 32'd0);
    check("t6.held_pnd", 32'(bus.pending),   32'd0);
    bus.irq_in = '0;
    step(3);
    bus.irq_in = 4'b0100;
    wait_req(1'b0, "t6re");
    check("t6re.irq_id", 32'(bus.irq_id), 32'd2);
    bus.irq_in = '0;
    ack(32'h604);
    finish_isr();
    step(2);

    // Randomized bursts: pulses land with everything masked, then a random
    // mask is applied and the model dictates the service order.
    m_pend = '0;
    m_nmi  = 1'b0;
    for (int r = 0; r < 24; r++) begin
      write_mask('0);
      m_mask = '0;
      bits = N'($urandom_range(0, (1 << N) - 1));
      nmi  = ($urandom_range(0, 3) == 0);
      pulse(bits, nmi);
      m_pend = m_pend | bits;
      m_nmi  = m_nmi | nmi;
      step(3);
      msk = N'($urandom_range(0, (1 << N) - 1));
      write_mask(msk);
      m_mask = msk;
      serve_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
